// File: rtl/dmem_lane_arbiter_pkg.sv
// Shared types and default widths for the dual-lane dmem arbiter.
// Optional one-cycle store-forwarding on same-address conflicts: DMEM_BYPASS_EN.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_lane_arbiter_if.sv
// Bus between the M-stage lanes, the arbiter and the dmem instance.
// slave = arbiter view; master = pipeline plus memory view.
interface dmem_lane_arbiter_if #(
    parameter int ADDR_W = dmem_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = dmem_arb_pkg::DEF_DATA_W,
    parameter int CNT_W  = dmem_arb_pkg::DEF_CNT_W
) ();

    // Lane side: req_* qualifies the other lane fields for the current cycle only;
    // there is no ready, the pipeline instead honours stall by holding XM.
    logic              req_t;
    logic              we_t;
    logic [ADDR_W-1:0] addr_t;
    logic [DATA_W-1:0] wdata_t;
    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              kill_b;
    logic [DATA_W-1:0] rdata_t;
    logic [DATA_W-1:0] rdata_b;
    logic              stall;
    logic [CNT_W-1:0]  conflict_cnt;
    dmem_arb_pkg::arb_state_e dbg_state;

    // Memory side
    logic [ADDR_W-1:0] address_dmem;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q_dmem;

    modport slave (
        input  req_t, we_t, addr_t, wdata_t,
        input  req_b, we_b, addr_b, wdata_b, kill_b,
        input  q_dmem,
        output address_dmem, data, wren,
        output rdata_t, rdata_b, stall, conflict_cnt, dbg_state
    );

    modport master (
        output req_t, we_t, addr_t, wdata_t,
        output req_b, we_b, addr_b, wdata_b, kill_b,
        output q_dmem,
        input  address_dmem, data, wren,
        input  rdata_t, rdata_b, stall, conflict_cnt, dbg_state
    );

endinterface

// File: rtl/dmem_lane_arbiter_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and increment enable.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_lane_arbiter.sv
// Shares one dmem port between lanes T (older) and B (younger); same-cycle conflicts
// serialize T then B behind a one-cycle stall. Optional feature macro: DMEM_BYPASS_EN.
module dmem_lane_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    dmem_lane_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] hold_t_q, hold_t_d;
    mem_req_t          b_q, b_d;

    logic              eb;
    logic              conflict;
    logic              fast;
    logic              cnt_inc;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] data_o;
    logic              wren_o;
    logic [DATA_W-1:0] rdata_t_o;
    logic [DATA_W-1:0] rdata_b_o;
    logic              stall_o;

    assign eb       = bus.req_b & ~bus.kill_b;
    assign conflict = bus.req_t & eb;

`ifdef DMEM_BYPASS_EN
    // T store to B's address: one write suffices; a B load sees T's data directly.
    assign fast = conflict & bus.we_t & (bus.addr_t == bus.addr_b);
`else
    assign fast = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        hold_t_d  = hold_t_q;
        b_d       = b_q;
        cnt_inc   = 1'b0;
        addr_o    = '0;
        data_o    = '0;
        wren_o    = 1'b0;
        rdata_t_o = '0;
        rdata_b_o = '0;
        stall_o   = 1'b0;
        if (reset) begin
            unique case (state_q)
                IDLE: begin
                    if (fast) begin
                        addr_o    = bus.addr_t;
                        wren_o    = 1'b1;
                        data_o    = bus.we_b ? bus.wdata_b : bus.wdata_t;
                        rdata_b_o = bus.we_b ? '0 : bus.wdata_t;
                    end else if (conflict) begin
                        addr_o   = bus.addr_t;
                        wren_o   = bus.we_t;
                        data_o   = bus.wdata_t;
                        stall_o  = 1'b1;
                        hold_t_d = bus.we_t ? '0 : bus.q_dmem;
                        b_d      = '{we: bus.we_b, addr: bus.addr_b, wdata: bus.wdata_b};
                        cnt_inc  = 1'b1;
                        state_d  = SECOND;
                    end else if (bus.req_t) begin
                        addr_o    = bus.addr_t;
                        wren_o    = bus.we_t;
                        data_o    = bus.wdata_t;
                        rdata_t_o = bus.we_t ? '0 : bus.q_dmem;
                    end else if (eb) begin
                        addr_o    = bus.addr_b;
                        wren_o    = bus.we_b;
                        data_o    = bus.wdata_b;
                        rdata_b_o = bus.we_b ? '0 : bus.q_dmem;
                    end
                end
                SECOND: begin
                    // A late flush still releases T's held result; only B is dropped.
                    rdata_t_o = hold_t_q;
                    if (!bus.kill_b) begin
                        addr_o    = b_q.addr;
                        wren_o    = b_q.we;
                        data_o    = b_q.wdata;
                        rdata_b_o = b_q.we ? '0 : bus.q_dmem;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            hold_t_q <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            hold_t_q <= hold_t_d;
            b_q      <= b_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_conflict_cnt (
        .clk_i  (clock),
        .rst_ni (reset),
        .inc_i  (cnt_inc),
        .cnt_o  (bus.conflict_cnt)
    );

    assign bus.address_dmem = addr_o;
    assign bus.data         = data_o;
    assign bus.wren         = wren_o;
    assign bus.rdata_t      = rdata_t_o;
    assign bus.rdata_b      = rdata_b_o;
    assign bus.stall        = stall_o;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Directed bench for dmem_lane_arbiter (default build) with a negedge-clocked dmem model.
module tb_dmem_lane_arbiter;
    import dmem_arb_pkg::*;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    dmem_lane_arbiter_if #(.ADDR_W(12), .DATA_W(32), .CNT_W(16)) bus ();

    dmem_lane_arbiter #(.ADDR_W(12), .DATA_W(32), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic        sc_rst_n;
    logic        sc_inc;
    logic [15:0] sc_cnt;

    sat_counter #(.CNT_W(16)) u_sc (
        .clk_i  (clock),
        .rst_ni (sc_rst_n),
        .inc_i  (sc_inc),
        .cnt_o  (sc_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // dmem model: combinational read, write on the falling edge
    logic [31:0] mem [0:4095];
    bit          wr_valid [0:4095];

    function automatic logic [31:0] init_val(input logic [11:0] a);
        case (a)
            12'h010: return 32'hDEADBEEF;
            12'h004: return 32'h0000_0011;
            12'h008: return 32'h0000_0022;
            default: return 32'hA000_0000 | {20'h0, a};
        endcase
    endfunction

    always @(negedge clock) begin
        if (bus.wren) begin
            mem[bus.address_dmem]      <= bus.data;
            wr_valid[bus.address_dmem] <= 1'b1;
        end
    end

    assign bus.q_dmem = wr_valid[bus.address_dmem] ? mem[bus.address_dmem]
                                                   : init_val(bus.address_dmem);

    typedef struct {
        string       name;
        logic        req_t, we_t;
        logic [11:0] addr_t;
        logic [31:0] wdata_t;
        logic        req_b, we_b;
        logic [11:0] addr_b;
        logic [31:0] wdata_b;
        logic        kill_b;
        logic [11:0] e_addr;
        logic        e_wren;
        logic [31:0] e_data, e_rt, e_rb;
        logic        e_stall;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rt, input logic wt, input logic [11:0] at, input logic [31:0] dt,
                         input logic rb, input logic wb, input logic [11:0] ab, input logic [31:0] db,
                         input logic kb);
        bus.req_t = rt; bus.we_t = wt; bus.addr_t = at; bus.wdata_t = dt;
        bus.req_b = rb; bus.we_b = wb; bus.addr_b = ab; bus.wdata_b = db;
        bus.kill_b = kb;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string n, input logic [11:0] a, input logic w,
                              input logic [31:0] d, input logic [31:0] rt,
                              input logic [31:0] rb, input logic s);
        check({n, ".addr"},  {20'h0, bus.address_dmem}, {20'h0, a});
        check({n, ".wren"},  {31'h0, bus.wren}, {31'h0, w});
        check({n, ".data"},  bus.data, d);
        check({n, ".rdt"},   bus.rdata_t, rt);
        check({n, ".rdb"},   bus.rdata_b, rb);
        check({n, ".stall"}, {31'h0, bus.stall}, {31'h0, s});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sc_rst_n = 1'b0;
        sc_inc   = 1'b0;
        reset    = 1'b0;
        idle_in();

        vecs[0] = '{"t_load",   1,0,12'h010,32'h0,      0,0,12'h0,  32'h0,     0, 12'h010,0,32'h0,      32'hDEADBEEF,32'h0,  0};
        vecs[1] = '{"b_load",   0,0,12'h0,  32'h0,      1,0,12'h008,32'h0,     0, 12'h008,0,32'h0,      32'h0,       32'h22, 0};
        vecs[2] = '{"none",     0,0,12'h0,  32'h0,      0,0,12'h0,  32'h0,     0, 12'h000,0,32'h0,      32'h0,       32'h0,  0};
        vecs[3] = '{"t_store",  1,1,12'h030,32'h1234,   0,0,12'h0,  32'h0,     0, 12'h030,1,32'h1234,   32'h0,       32'h0,  0};
        vecs[4] = '{"b_killed", 0,0,12'h0,  32'h0,      1,0,12'h008,32'h0,     1, 12'h000,0,32'h0,      32'h0,       32'h0,  0};
        vecs[5] = '{"t_kill_b", 1,0,12'h004,32'h0,      1,1,12'h040,32'hBAD,   1, 12'h004,0,32'h0,      32'h11,      32'h0,  0};
        vecs[6] = '{"b_store",  0,0,12'h0,  32'h0,      1,1,12'h040,32'hCAFE,  0, 12'h040,1,32'hCAFE,   32'h0,       32'h0,  0};

        // Reset: inputs active but outputs held quiet
        step();
        drive(1'b1, 1'b1, 12'h070, 32'h77, 1'b1, 1'b0, 12'h008, 32'h0, 1'b0);
        #3;
        check("rst.wren",  {31'h0, bus.wren}, 32'h0);
        check("rst.stall", {31'h0, bus.stall}, 32'h0);
        check("rst.rdt",   bus.rdata_t, 32'h0);
        check("rst.rdb",   bus.rdata_b, 32'h0);
        check("rst.cnt",   {16'h0, bus.conflict_cnt}, 32'h0);
        check("rst.state", {31'h0, bus.dbg_state}, {31'h0, IDLE});
        step();
        idle_in();
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            step();
            drive(vecs[i].req_t, vecs[i].we_t, vecs[i].addr_t, vecs[i].wdata_t,
                  vecs[i].req_b, vecs[i].we_b, vecs[i].addr_b, vecs[i].wdata_b, vecs[i].kill_b);
            #3;
            check_outs(vecs[i].name, vecs[i].e_addr, vecs[i].e_wren, vecs[i].e_data,
                       vecs[i].e_rt, vecs[i].e_rb, vecs[i].e_stall);
        end

        // Dual loads; SECOND must ignore the new request
        step();
        drive(1'b1, 1'b0, 12'h004, 32'h0, 1'b1, 1'b0, 12'h008, 32'h0, 1'b0);
        #3;
        check_outs("dual.c1", 12'h004, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        step();
        drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
        #3;
        check_outs("dual.c2", 12'h008, 1'b0, 32'h0, 32'h11, 32'h22, 1'b0);
        check("dual.cnt",   {16'h0, bus.conflict_cnt}, 32'd1);
        check("dual.state", {31'h0, bus.dbg_state}, {31'h0, SECOND});
        step();
        idle_in();
        #3;
        check("dual.back", {31'h0, bus.dbg_state}, {31'h0, IDLE});
        check("dual.idle_addr", {20'h0, bus.address_dmem}, 32'h0);

        // T store then B load to the same address returns the new data
        step();
        drive(1'b1, 1'b1, 12'h020, 32'h55, 1'b1, 1'b0, 12'h020, 32'h0, 1'b0);
        #3;
        check_outs("stld.c1", 12'h020, 1'b1, 32'h55, 32'h0, 32'h0, 1'b1);
        step();
        idle_in();
        #3;
        check_outs("stld.c2", 12'h020, 1'b0, 32'h0, 32'h0, 32'h55, 1'b0);
        check("stld.cnt", {16'h0, bus.conflict_cnt}, 32'd2);

        // B store carried into SECOND
        step();
        drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 1'b1, 12'h060, 32'h7777, 1'b0);
        #3;
        check_outs("ldst.c1", 12'h010, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        step();
        idle_in();
        #3;
        check_outs("ldst.c2", 12'h060, 1'b1, 32'h7777, 32'hDEADBEEF, 32'h0, 1'b0);
        check("ldst.cnt", {16'h0, bus.conflict_cnt}, 32'd3);
        step();
        check("ldst.mem", mem[12'h060], 32'h7777);

        // kill_b in SECOND drops B but releases held T data
        step();
        drive(1'b1, 1'b0, 12'h004, 32'h0, 1'b1, 1'b0, 12'h008, 32'h0, 1'b0);
        #3;
        check("kill.c1.stall", {31'h0, bus.stall}, 32'h1);
        step();
        drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h008, 32'h0, 1'b1);
        #3;
        check_outs("kill.c2", 12'h000, 1'b0, 32'h0, 32'h11, 32'h0, 1'b0);
        check("kill.cnt", {16'h0, bus.conflict_cnt}, 32'd4);
        step();
        drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
        #3;
        check("kill.state", {31'h0, bus.dbg_state}, {31'h0, IDLE});
        check_outs("kill.c3", 12'h010, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0);

        // Reset during SECOND abandons the pending B store
        step();
        drive(1'b1, 1'b0, 12'h004, 32'h0, 1'b1, 1'b1, 12'h050, 32'h9999, 1'b0);
        #3;
        check("rsec.c1.stall", {31'h0, bus.stall}, 32'h1);
        step();
        idle_in();
        reset = 1'b0;
        #3;
        check("rsec.wren",  {31'h0, bus.wren}, 32'h0);
        check("rsec.stall", {31'h0, bus.stall}, 32'h0);
        check("rsec.rdt",   bus.rdata_t, 32'h0);
        step();
        reset = 1'b1;
        #3;
        check("rsec.cnt",   {16'h0, bus.conflict_cnt}, 32'h0);
        check("rsec.state", {31'h0, bus.dbg_state}, {31'h0, IDLE});
        check("rsec.nowr",  {31'h0, wr_valid[12'h050]}, 32'h0);

        // Saturating counter at full 16-bit width
        step();
        sc_rst_n = 1'b1;
        sc_inc   = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("sat.three", {16'h0, sc_cnt}, 32'd3);
        for (int k = 3; k < 65534; k++) step();
        check("sat.fffe", {16'h0, sc_cnt}, 32'h0000_FFFE);
        step();
        check("sat.ffff", {16'h0, sc_cnt}, 32'h0000_FFFF);
        for (int k = 0; k < 4; k++) step();
        check("sat.hold", {16'h0, sc_cnt}, 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
